// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and a 2-of-3
// majority helper, used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 1 so an idle
// high line produces no spurious edge when reset is released.
module uart_sync_2ff (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage metastability filter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: 1 start, 8 data (LSB first), 1 stop, no parity.
// Define RX_MAJORITY_EN to take each START/DATA/STOP sample as the 2-of-3
// majority of the synchronized line at counts N-2, N-1 and N; output timing
// is the same in either build.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned UART_BPS = 9600,
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_flag,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int unsigned HALF_CNT     = BAUD_CNT_MAX / 2;
    localparam logic [15:0] BIT_SAMPLE   = 16'(BAUD_CNT_MAX - 1);
    localparam logic [15:0] START_SAMPLE = 16'(HALF_CNT - 1);

    uart_state_t          state, state_next;
    logic                 rx_sync;
    logic                 rx_d;
    logic                 start_edge;
    logic [15:0]          baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 sample_pt;
    logic                 sample_bit;

    uart_sync_2ff u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .d         (rx),
        .q         (rx_sync)
    );

    // Previous synchronized value, used for falling-edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rx_d <= 1'b1;
        else            rx_d <= rx_sync;
    end

    assign start_edge = rx_d & ~rx_sync;

`ifdef RX_MAJORITY_EN
    logic rx_d2;

    // Second history tap so the vote spans counts N-2, N-1 and N.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rx_d2 <= 1'b1;
        else            rx_d2 <= rx_d;
    end

    assign sample_bit = maj3(rx_d2, rx_d, rx_sync);
`else
    assign sample_bit = rx_sync;
`endif

    // Sample point: half bit in START, mid-bit in DATA and STOP.
    always_comb begin
        sample_pt = 1'b0;
        case (state)
            START:       sample_pt = (baud_cnt == START_SAMPLE);
            DATA, STOP:  sample_pt = (baud_cnt == BIT_SAMPLE);
            default:     sample_pt = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_edge) state_next = START;
            START: if (sample_pt)  state_next = (sample_bit == START_BIT) ? DATA : IDLE;
            DATA:  if (sample_pt && bit_cnt == 3'(DATA_BITS - 1)) state_next = STOP;
            STOP:  if (sample_pt)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign rx_busy = (state != IDLE);

    // Every sample point either changes state or wraps a DATA bit, so clearing
    // on sample_pt (and holding 0 in IDLE) clears the counter on every state entry.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                       baud_cnt <= '0;
        else if (state == IDLE || sample_pt)  baud_cnt <= '0;
        else                                  baud_cnt <= baud_cnt + 16'd1;
    end

    // Data bit counter and LSB-first shift register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (state != DATA) begin
            bit_cnt   <= '0;
        end else if (sample_pt) begin
            bit_cnt   <= bit_cnt + 3'd1;
            shift_reg <= {sample_bit, shift_reg[DATA_BITS-1:1]};
        end
    end

    // Frame result: load byte and pulse flag on a good stop bit, else pulse error.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_data      <= '0;
            rx_flag      <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_flag      <= 1'b0;
            rx_frame_err <= 1'b0;
            if (state == STOP && sample_pt) begin
                if (sample_bit == STOP_BIT) begin
                    rx_data <= shift_reg;
                    rx_flag <= 1'b1;
                end else begin
                    rx_frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame at 115200 bit/s on a 50 MHz clock.
module tb_uart_rx_frame;

    localparam int unsigned BAUD = 434;
    localparam int unsigned HALF = 217;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       rx_frame_err;
    logic       rx_busy;

    int   n_cmp;
    int   n_fail;
    exp_t sb[$];

    uart_rx_frame #(
        .UART_BPS (115200),
        .CLK_FREQ (50_000_000)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_flag      (rx_flag),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, req);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic push(input logic is_err, input logic [7:0] data);
        exp_t e;
        e.is_err = is_err;
        e.data   = data;
        sb.push_back(e);
    endtask

    // Drive one frame, optionally truncated after ncyc cycles; glitch inverts
    // the line for one cycle at the centre of each data bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_lvl,
                              input bit glitch, input int unsigned ncyc);
        logic [9:0]  frame;
        int unsigned n;
        frame = {stop_lvl, data, 1'b0};
        n = 0;
        for (int b = 0; b < 10; b++) begin
            for (int unsigned c = 0; c < BAUD; c++) begin
                if (n == ncyc) return;
                rx = frame[b];
                if (glitch && b >= 1 && b <= 8 && c == HALF) rx = ~frame[b];
                tick(1);
                n++;
            end
        end
    endtask

    // Monitor: every output pulse is matched against the oldest expectation.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (rx_flag && rx_frame_err) begin
                n_cmp++;
                n_fail++;
                $display("FAIL pulse_overlap: got flag=1 err=1 expected at most one");
            end else if (rx_flag || rx_frame_err) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: got flag=%0b err=%0b data=0x%02h expected none",
                             rx_flag, rx_frame_err, rx_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.is_err !== rx_frame_err || e.data !== rx_data) begin
                        n_fail++;
                        $display("FAIL frame_result: got err=%0b data=0x%02h expected err=%0b data=0x%02h",
                                 rx_frame_err, rx_data, e.is_err, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rx        = 1'b1;
        sys_rst_n = 1'b0;
        tick(5);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_flag", {7'd0, rx_flag}, 8'h00);
        check("reset_rx_err",  {7'd0, rx_frame_err}, 8'h00);
        check("reset_rx_busy", {7'd0, rx_busy}, 8'h00);
        sys_rst_n = 1'b1;
        tick(20);

        // V1: plain byte
        push(1'b0, 8'h55);
        send_frame(8'h55, 1'b1, 1'b0, 10 * BAUD);
        tick(10);
        check("v1_rx_data", rx_data, 8'h55);
        check("v1_busy_low", {7'd0, rx_busy}, 8'h00);

        // V2: short low glitch on an idle line
        rx = 1'b0;
        tick(50);
        check("v2_busy_in_start", {7'd0, rx_busy}, 8'h01);
        tick(50);
        rx = 1'b1;
        tick(400);
        check("v2_busy_low", {7'd0, rx_busy}, 8'h00);
        check("v2_rx_data_kept", rx_data, 8'h55);

        // V3: good byte then a framing error with the line left low
        push(1'b0, 8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 10 * BAUD);
        push(1'b1, 8'h3C);
        send_frame(8'hA3, 1'b0, 1'b0, 10 * BAUD);
        rx = 1'b0;
        tick(500);
        check("v3_no_restart_low", {7'd0, rx_busy}, 8'h00);
        rx = 1'b1;
        tick(20);
        check("v3_busy_low", {7'd0, rx_busy}, 8'h00);
        check("v3_rx_data_kept", rx_data, 8'h3C);

        // V4: back-to-back frames, no idle gap
        push(1'b0, 8'hA3);
        push(1'b0, 8'h0F);
        send_frame(8'hA3, 1'b1, 1'b0, 10 * BAUD);
        send_frame(8'h0F, 1'b1, 1'b0, 10 * BAUD);
        tick(10);
        check("v4_rx_data", rx_data, 8'h0F);

        // V5: reset during data bit 4 of 0xFF
        send_frame(8'hFF, 1'b1, 1'b0, 5 * BAUD + 200);
        sys_rst_n = 1'b0;
        rx = 1'b1;
        tick(1);
        check("v5_rst_rx_data", rx_data, 8'h00);
        check("v5_rst_rx_flag", {7'd0, rx_flag}, 8'h00);
        check("v5_rst_rx_err",  {7'd0, rx_frame_err}, 8'h00);
        check("v5_rst_rx_busy", {7'd0, rx_busy}, 8'h00);
        tick(20);
        sys_rst_n = 1'b1;
        tick(BAUD);
        check("v5_idle_after_rst", {7'd0, rx_busy}, 8'h00);
        push(1'b0, 8'h81);
        send_frame(8'h81, 1'b1, 1'b0, 10 * BAUD);
        tick(10);
        check("v5_rx_data", rx_data, 8'h81);

        // V6: one-cycle inverted glitch at each data sample point
`ifdef RX_MAJORITY_EN
        push(1'b0, 8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1, 10 * BAUD);
        tick(10);
        check("v6_rx_data", rx_data, 8'h5A);
`else
        push(1'b0, 8'hA5);
        send_frame(8'h5A, 1'b1, 1'b1, 10 * BAUD);
        tick(10);
        check("v6_rx_data", rx_data, 8'hA5);
`endif

        tick(BAUD);
        check("scoreboard_drained", 8'(sb.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter UART_BPS, default 9600, line baud rate in bit/s.
REQ-002 Parameter CLK_FREQ, default 50_000_000, sys_clk frequency in Hz.
REQ-003 sys_clk  input  1  system clock; all logic on the rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx  input  1  serial line, asynchronous to sys_clk, idle high.
REQ-006 rx_data  output  8  last correctly framed byte, held until the next good frame.
REQ-007 rx_flag  output  1  one-cycle pulse marking a new rx_data.
REQ-008 rx_frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 BAUD_CNT_MAX SHALL equal CLK_FREQ/UART_BPS (integer division, 5208 at defaults); HALF_CNT SHALL equal BAUD_CNT_MAX/2.
REQ-012 rx SHALL pass through a 2-flop synchronizer, plus one more flop for edge detection; the start edge is synchronized-previous=1 and synchronized-current=0.
REQ-013 FSM states SHALL be IDLE, START, DATA and STOP; the baud counter is 16 bits and is cleared on every state entry.
REQ-014 IDLE->START on a detected start edge; no other condition leaves IDLE.
REQ-015 In START, the line SHALL be sampled at baud_cnt==HALF_CNT-1. If the sample is 1, the FSM returns to IDLE with no output pulse (glitch rejection). If it is 0, the FSM goes to DATA.
REQ-016 In DATA, a sample SHALL be taken at baud_cnt==BAUD_CNT_MAX-1 (mid-bit), then the counter wraps to 0. The sample shifts into the MSB of an 8-bit shift register, which shifts right. A 3-bit bit counter advances; after the 8th sample the FSM goes to STOP.
REQ-017 In STOP, the line SHALL be sampled at baud_cnt==BAUD_CNT_MAX-1, and the FSM then goes to IDLE.
- Sample 1: rx_data is loaded from the shift register and rx_flag pulses in the same clock edge, exactly one cycle after the sample cycle.
- Sample 0: rx_frame_err pulses instead, and rx_data is unchanged.
REQ-018 rx_flag and rx_frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-019 After a framing error with the line held low, no new frame SHALL start until the line has been seen high and a fresh start edge occurs.
REQ-020 The FSM SHALL return to IDLE mid-stop-bit, so a back-to-back start edge is detected with no extra idle time required.

Reset
REQ-021 Under sys_rst_n low, the following SHALL be reset:
- FSM to IDLE.
- Counters and shift register to 0.
- rx_data to 8'h00.
- rx_flag, rx_frame_err and rx_busy to 0.
- Synchronizer and edge flops to 1.
REQ-022 Reset asserted mid-frame SHALL discard the partial byte. After release, reception SHALL resume only at the next start edge.

Configuration
REQ-023 Macro RX_MAJORITY_EN SHALL control majority-vote sampling.
- Defined: each START, DATA and STOP sample is the 2-of-3 majority of the synchronized line at counts N-2, N-1 and N, where N is the nominal sample count.
- Undefined: each sample is the single synchronized value at count N.
- Timing of all outputs is identical in both builds.

Structure
REQ-024 A shared package uart_pkg SHALL hold the FSM state enumeration and the frame constants (DATA_BITS=8, start and stop bit levels). The transmitter and receiver share this package.
REQ-025 The synchronizer SHALL be a separate sub-module uart_sync_2ff (1-bit input, reset value 1). All other logic stays in uart_rx_frame.

Verification
REQ-026 Sim with UART_BPS=115200 (BAUD_CNT_MAX=434). The bench SHALL cover the following scenarios.
- V1: Send byte 0x55 with a valid stop bit -> rx_data=0x55, one rx_flag pulse, no rx_frame_err, rx_busy low afterwards.
- V2: Drive a 100-cycle low glitch on an idle line -> FSM returns to IDLE at the START sample; no rx_flag, no rx_frame_err.
- V3: Receive 0x3C, then send 0xA3 with the stop bit driven 0 -> rx_frame_err pulse, rx_data stays 0x3C, no rx_flag.
- V4: Send 0xA3 then 0x0F back-to-back with zero idle gap -> two rx_flag pulses, rx_data=0xA3 then 0x0F.
- V5: Assert sys_rst_n low during data bit 4 of 0xFF, release, then send 0x81 -> all outputs 0 during reset, then a single rx_flag with rx_data=0x81.
- V6 (RX_MAJORITY_EN defined): Insert a 1-cycle inverted glitch at each DATA sample point of 0x5A -> rx_data=0x5A. With the macro undefined, the same stimulus SHALL yield 0xA5.
